symbol_gen: RTL and testbench
=============================

SYMBOL_GEN -- requirements
Module: symbol_gen

Interface
REQ-001 Parameter NUM_SYMBOLS, default 20: symbols emitted per game period (range 1..255).
REQ-002 Parameter BASE_INTERVAL, default 32: emission interval in ticks at level 0.
REQ-003 Parameter SEED, default 8'hA5: LFSR load value; must be nonzero.
REQ-004 Clk  in  1  single clock; all state changes on posedge Clk.
REQ-005 Rst_n  in  1  reset, synchronous, active-low.
REQ-006 gamePeriod  in  1  level; high for the duration of the game period.
REQ-007 level  in  5  difficulty; sampled at each interval reload.
REQ-008 tick  in  1  single-cycle timebase enable.
REQ-009 generatedSymbol  out  8  active-low seven-segment pattern of the current symbol, bit7 = dp.
REQ-010 symValid  out  1  one-cycle pulse, high in the cycle generatedSymbol changes.
REQ-011 targetSymbol  out  8  seven-segment pattern of the symbol the player counts.
REQ-012 symCount  out  8  number of emitted symbols equal to the target.
REQ-013 genDone  out  1  high once NUM_SYMBOLS have been emitted.

Function
REQ-014 FSM states IDLE, LOAD, RUN, DONE; IDLE->LOAD on the cycle after gamePeriod is first sampled high following a low sample (registered edge detect).
REQ-015 LOAD, one cycle: lfsr=SEED, target index=SEED[2:0], symCount=0, emitted=0, tick counter=0, genDone=0, generatedSymbol=8'hFF; ->RUN.
REQ-016 Interval = BASE_INTERVAL - min(level,24) ticks; the tick counter increments only on tick.
REQ-017 On the tick that brings the counter to interval: counter=0; lfsr advances once; index=lfsr_next[2:0]; outputs update at the following posedge with symValid=1.
REQ-018 LFSR: 8-bit Fibonacci, shift left, new bit0 = l[7]^l[5]^l[4]^l[3].
REQ-019 Symbol table, index 0..7 -> C0,F9,A4,B0,99,92,82,F8 (digits 0..7).
REQ-020 symCount increments when the emitted index equals the target index, saturating at 255.
REQ-021 After the NUM_SYMBOLS-th emission: ->DONE, genDone=1, with generatedSymbol, symCount, and targetSymbol held.
REQ-022 gamePeriod sampled low in LOAD, RUN, or DONE: ->IDLE next cycle; symCount, targetSymbol, and genDone hold; generatedSymbol=8'hFF.
REQ-023 In IDLE and DONE, tick is ignored and symValid=0.
REQ-024 The tick counter increments only while symValid is low or is unaffected by it; an emission and a tick in the same cycle each take effect.

Reset
REQ-025 Rst_n low at posedge Clk: state=IDLE, generatedSymbol=8'hFF, targetSymbol=8'hFF, symValid=0, symCount=0, genDone=0, lfsr=SEED, edge-detect register=0.
REQ-026 Reset dominates any state, including mid-RUN; gamePeriod already high at reset release does not start a game until it is seen low and then high.

Configuration
REQ-027 Macro SYMGEN_NOREPEAT_EN defined: if the new index equals the previously emitted index, the block uses (index+1) mod 8 instead; the LFSR is unaffected. Macro undefined: indices are used unmodified.

Structure
REQ-028 The shared package symgen_pkg holds the FSM state enum, the 8-entry symbol table constant, and SYM_BLANK=8'hFF.
REQ-029 The sub-module symgen_lfsr (8-bit, load and advance enables) is instantiated once; all other logic resides in symbol_gen.

Verification
REQ-030 Rst_n low for 2 cycles -> generatedSymbol=FF, targetSymbol=FF, symCount=0, symValid=0, genDone=0.
REQ-031 gamePeriod rises, level=0, tick every cycle -> targetSymbol=92 after LOAD; first symValid 32 ticks later with A4; second with 92 and symCount=1.
REQ-032 level=31 -> interval 8 ticks, identical to level=24; level=10 -> 22 ticks between symValid pulses.
REQ-033 NUM_SYMBOLS=20 -> exactly 20 symValid pulses, then genDone=1 held; further ticks produce no pulse.
REQ-034 gamePeriod drops after 5 symbols -> IDLE, generatedSymbol=FF, symCount held; re-raise -> LOAD clears symCount to 0.
REQ-035 SYMGEN_NOREPEAT_EN defined, 200 symbols -> no two consecutive equal generatedSymbol values; undefined -> sequence matches the LFSR model exactly.

Source files
------------

// File: rtl/symgen_pkg.sv
// Shared definitions for the symbol generator: FSM states, the digit glyph table
// and the blank pattern.
package symgen_pkg;

  typedef enum logic [1:0] {IDLE, LOAD, RUN, DONE} state_t;

  localparam logic [7:0] SYM_BLANK = 8'hFF;

  // Active-low seven-segment glyphs for digits 0..7, bit7 = dp
  localparam logic [7:0] SYM_TABLE [8] = '{
    8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8
  };

  function automatic logic [7:0] sym_lookup(input logic [2:0] idx);
    return SYM_TABLE[idx];
  endfunction

endpackage

// File: rtl/symgen_lfsr.sv
// 8-bit Fibonacci LFSR (shift left, taps 7/5/4/3) with load and advance enables.
// Exposes the next value so the caller can use it in the same cycle it advances.
module symgen_lfsr #(
  parameter logic [7:0] SEED = 8'hA5
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       load,
  input  logic       advance,
  output logic [7:0] next_value
);

  logic [7:0] value;

  assign next_value = {value[6:0], value[7] ^ value[5] ^ value[4] ^ value[3]};

  always_ff @(posedge clk) begin
    if (!rst_n)       value <= SEED;
    else if (load)    value <= SEED;
    else if (advance) value <= next_value;
  end

endmodule

// File: rtl/symbol_gen.sv
// Pseudo-random seven-segment symbol generator for a counting game.
// Optional build macro SYMGEN_NOREPEAT_EN suppresses back-to-back repeated indices.
module symbol_gen
  import symgen_pkg::*;
#(
  parameter int unsigned NUM_SYMBOLS   = 20,
  parameter int unsigned BASE_INTERVAL = 32,
  parameter logic [7:0]  SEED          = 8'hA5
) (
  input  logic       Clk,
  input  logic       Rst_n,
  input  logic       gamePeriod,
  input  logic [4:0] level,
  input  logic       tick,
  output logic [7:0] generatedSymbol,
  output logic       symValid,
  output logic [7:0] targetSymbol,
  output logic [7:0] symCount,
  output logic       genDone
);

  state_t      state, state_next;
  logic        gp_low_q;
  logic        rise;
  logic [15:0] tick_cnt, interval_q, interval_now;
  logic [4:0]  lvl_clamp;
  logic [7:0]  emitted;
  logic [2:0]  target_idx, raw_idx, emit_idx;
  logic        emit, last_emit;
  logic        lfsr_load, lfsr_adv;
  logic [7:0]  lfsr_next;

  symgen_lfsr #(.SEED(SEED)) u_lfsr (
    .clk       (Clk),
    .rst_n     (Rst_n),
    .load      (lfsr_load),
    .advance   (lfsr_adv),
    .next_value(lfsr_next)
  );

  // gp_low_q resets to 0, so a level already high at reset release is not an edge
  assign rise = gamePeriod & gp_low_q;

  assign lvl_clamp    = (level > 5'd24) ? 5'd24 : level;
  assign interval_now = 16'(BASE_INTERVAL) - {11'd0, lvl_clamp};

  assign emit      = (state == RUN) && gamePeriod && tick && ((tick_cnt + 16'd1) == interval_q);
  assign last_emit = ((emitted + 8'd1) == 8'(NUM_SYMBOLS));
  assign raw_idx   = lfsr_next[2:0];

`ifdef SYMGEN_NOREPEAT_EN
  logic [2:0] last_idx;
  assign emit_idx = ((emitted != 8'd0) && (raw_idx == last_idx)) ? raw_idx + 3'd1 : raw_idx;
`else
  assign emit_idx = raw_idx;
`endif

  always_ff @(posedge Clk) begin
    if (!Rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    lfsr_load  = 1'b0;
    lfsr_adv   = 1'b0;
    case (state)
      IDLE: if (rise) state_next = LOAD;
      LOAD: begin
        state_next = gamePeriod ? RUN : IDLE;
        lfsr_load  = gamePeriod;
      end
      RUN: begin
        if (!gamePeriod) state_next = IDLE;
        else if (emit && last_emit) state_next = DONE;
        lfsr_adv = emit;
      end
      DONE: if (!gamePeriod) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (!Rst_n) begin
      gp_low_q        <= 1'b0;
      generatedSymbol <= SYM_BLANK;
      targetSymbol    <= SYM_BLANK;
      symValid        <= 1'b0;
      symCount        <= '0;
      genDone         <= 1'b0;
      tick_cnt        <= '0;
      interval_q      <= 16'(BASE_INTERVAL);
      emitted         <= '0;
      target_idx      <= SEED[2:0];
`ifdef SYMGEN_NOREPEAT_EN
      last_idx        <= '0;
`endif
    end else begin
      gp_low_q <= ~gamePeriod;
      symValid <= 1'b0;
      case (state)
        LOAD: begin
          generatedSymbol <= SYM_BLANK;
          if (gamePeriod) begin
            target_idx   <= SEED[2:0];
            targetSymbol <= sym_lookup(SEED[2:0]);
            symCount     <= '0;
            emitted      <= '0;
            tick_cnt     <= '0;
            genDone      <= 1'b0;
            interval_q   <= interval_now;
          end
        end
        RUN: begin
          if (!gamePeriod) begin
            generatedSymbol <= SYM_BLANK;
          end else if (emit) begin
            tick_cnt        <= '0;
            generatedSymbol <= sym_lookup(emit_idx);
            symValid        <= 1'b1;
            emitted         <= emitted + 8'd1;
            interval_q      <= interval_now;
`ifdef SYMGEN_NOREPEAT_EN
            last_idx        <= emit_idx;
`endif
            if ((emit_idx == target_idx) && (symCount != 8'hFF)) symCount <= symCount + 8'd1;
            if (last_emit) genDone <= 1'b1;
          end else if (tick) begin
            tick_cnt <= tick_cnt + 16'd1;
          end
        end
        DONE: if (!gamePeriod) generatedSymbol <= SYM_BLANK;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_symbol_gen.sv
// Self-checking bench for symbol_gen: directed game scenarios plus randomized
// ticks/levels, checked every cycle against a game-level reference model.
module tb_symbol_gen;

  localparam int         NUM  = 20;
  localparam int         BASE = 32;
  localparam logic [7:0] SEED = 8'hA5;

  logic       Clk = 1'b0;
  logic       Rst_n, gamePeriod, tick;
  logic [4:0] level;
  logic [7:0] generatedSymbol, targetSymbol, symCount;
  logic       symValid, genDone;

  always #5 Clk = ~Clk;

  symbol_gen dut (
    .Clk            (Clk),
    .Rst_n          (Rst_n),
    .gamePeriod     (gamePeriod),
    .level          (level),
    .tick           (tick),
    .generatedSymbol(generatedSymbol),
    .symValid       (symValid),
    .targetSymbol   (targetSymbol),
    .symCount       (symCount),
    .genDone        (genDone)
  );

  int n_cmp = 0;
  int n_err = 0;

  logic [7:0] tbl [8] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8};
  int         seq [200];

  // Reference model state
  int         m_phase;   // 0 idle, 1 load, 2 run, 3 done
  bit         m_armed;
  int         m_ticks, m_interval, m_emitted, m_tidx;
  logic [7:0] m_sym, m_tgt, m_count;
  bit         m_done, m_valid;

  int         cyc_no = 0;
  int         pulse_t[$];
  logic [7:0] prev_obs_sym;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int lfsr_adv(input int x);
    int b;
    b = ((x >> 7) ^ (x >> 5) ^ (x >> 4) ^ (x >> 3)) & 1;
    return ((x << 1) & 8'hFF) | b;
  endfunction

  function automatic int interval_of(input int lvl);
    return BASE - ((lvl > 24) ? 24 : lvl);
  endfunction

  task automatic cyc(input bit rn, input bit gp, input int lvl, input bit tk);
    bit rise;
    int idx;
    Rst_n = rn; gamePeriod = gp; level = lvl[4:0]; tick = tk;
    @(posedge Clk);
    cyc_no++;
    m_valid = 0;
    if (!rn) begin
      m_phase = 0; m_sym = 8'hFF; m_tgt = 8'hFF; m_count = 0; m_done = 0; m_armed = 0;
    end else begin
      rise    = gp && m_armed;
      m_armed = !gp;
      case (m_phase)
        0: if (rise) m_phase = 1;
        1: begin
          m_sym = 8'hFF;
          if (!gp) m_phase = 0;
          else begin
            m_tidx = SEED & 7; m_tgt = tbl[m_tidx]; m_count = 0; m_emitted = 0;
            m_ticks = 0; m_done = 0; m_interval = interval_of(lvl); m_phase = 2;
          end
        end
        2: begin
          if (!gp) begin m_phase = 0; m_sym = 8'hFF; end
          else if (tk) begin
            m_ticks++;
            if (m_ticks == m_interval) begin
              m_ticks = 0;
              idx = seq[m_emitted];
              m_sym = tbl[idx];
              m_valid = 1;
              if (idx == m_tidx && m_count != 8'hFF) m_count++;
              m_emitted++;
              m_interval = interval_of(lvl);
              if (m_emitted == NUM) begin m_phase = 3; m_done = 1; end
            end
          end
        end
        default: if (!gp) begin m_phase = 0; m_sym = 8'hFF; end
      endcase
    end
    #1;
    check("generatedSymbol", {8'd0, generatedSymbol}, {8'd0, m_sym});
    check("symValid", {15'd0, symValid}, {15'd0, m_valid});
    check("targetSymbol", {8'd0, targetSymbol}, {8'd0, m_tgt});
    check("symCount", {8'd0, symCount}, {8'd0, m_count});
    check("genDone", {15'd0, genDone}, {15'd0, m_done});
    if (symValid) begin
`ifdef SYMGEN_NOREPEAT_EN
      if (pulse_t.size() > 0) begin
        n_cmp++;
        assert (generatedSymbol !== prev_obs_sym) else begin
          n_err++;
          $error("FAIL norepeat observed=%0h previous=%0h", generatedSymbol, prev_obs_sym);
        end
      end
`endif
      prev_obs_sym = generatedSymbol;
      pulse_t.push_back(cyc_no);
    end
  endtask

  // Start a game: low sample, rising sample, then the LOAD cycle
  task automatic start_game(input int lvl);
    cyc(1, 0, lvl, 1);
    cyc(1, 1, lvl, 1);
    cyc(1, 1, lvl, 1);
    pulse_t.delete();
  endtask

  task automatic run_until_pulses(input int n, input int lvl);
    for (int i = 0; i < 2000 && pulse_t.size() < n; i++) cyc(1, 1, lvl, 1);
    check("pulse_budget", 16'(pulse_t.size()), 16'(n));
  endtask

  initial begin
    int l, prev, load_cyc, cnt_hold;

    l = SEED; prev = -1;
    for (int k = 0; k < 200; k++) begin
      l = lfsr_adv(l);
      seq[k] = l & 7;
`ifdef SYMGEN_NOREPEAT_EN
      if (seq[k] == prev) seq[k] = (seq[k] + 1) % 8;
`endif
      prev = seq[k];
    end
    m_phase = 0; m_armed = 0; m_sym = 8'hFF; m_tgt = 8'hFF; m_count = 0; m_done = 0;
    m_ticks = 0; m_interval = BASE; m_emitted = 0; m_tidx = SEED & 7;

    // Reset with gamePeriod already high; it must not start a game on release
    cyc(0, 1, 0, 1);
    cyc(0, 1, 0, 1);
    check("reset_sym", {8'd0, generatedSymbol}, 16'h00FF);
    check("reset_target", {8'd0, targetSymbol}, 16'h00FF);
    repeat (6) cyc(1, 1, 0, 1);
    check("no_start_after_reset", {8'd0, targetSymbol}, 16'h00FF);

    // Level 0, tick every cycle
    start_game(0);
    load_cyc = cyc_no;
    check("target_after_load", {8'd0, targetSymbol}, 16'h0092);
    run_until_pulses(1, 0);
    check("first_sym", {8'd0, generatedSymbol}, 16'h00A4);
    check("first_latency", 16'(pulse_t[0] - load_cyc), 16'd32);
    run_until_pulses(2, 0);
    check("second_sym", {8'd0, generatedSymbol}, 16'h0092);
    check("second_count", {8'd0, symCount}, 16'd1);
    check("gap_level0", 16'(pulse_t[1] - pulse_t[0]), 16'd32);
    repeat (800) cyc(1, 1, 0, 1);
    check("pulses_per_game", 16'(pulse_t.size()), 16'(NUM));
    check("done_held", {15'd0, genDone}, 16'd1);

    // Level 31 clamps to 24: 8-tick interval; drop after 5 symbols
    start_game(31);
    run_until_pulses(3, 31);
    check("gap_level31", 16'(pulse_t[2] - pulse_t[1]), 16'd8);
    run_until_pulses(5, 31);
    cnt_hold = symCount;
    cyc(1, 0, 31, 1);
    check("drop_sym_blank", {8'd0, generatedSymbol}, 16'h00FF);
    check("drop_count_held", {8'd0, symCount}, 16'(cnt_hold));
    cyc(1, 1, 31, 1);
    cyc(1, 1, 31, 1);
    check("reload_clears_count", {8'd0, symCount}, 16'd0);

    // Level 10: 22 ticks between pulses
    start_game(10);
    run_until_pulses(2, 10);
    check("gap_level10", 16'(pulse_t[1] - pulse_t[0]), 16'd22);

    // Reset mid-RUN, then gamePeriod still high must not restart
    repeat (5) cyc(1, 1, 10, 1);
    cyc(0, 1, 10, 1);
    check("midrun_reset_count", {8'd0, symCount}, 16'd0);
    repeat (10) cyc(1, 1, 10, 1);

    // Randomized ticks, levels and occasional drops of gamePeriod
    for (int g = 0; g < 4; g++) begin
      start_game(int'($urandom_range(0, 31)));
      for (int i = 0; i < 900; i++)
        cyc(1, ($urandom_range(0, 399) != 0), int'($urandom_range(0, 31)), 1'($urandom_range(0, 1)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
